// File: rtl/sprite_line_sequencer_if.sv
// sprite_line_sequencer_if: signal bundle between video timing/renderer/line buffer and the sequencer
//   master: drives line_start, display_line, composer_line_done, sprites_enable, render_done, overrun_clr
//   slave : drives active_render_buffer, render_start, render_line, render_abort, composer_erase_start, status
interface sprite_line_sequencer_if;
  logic       line_start;
  logic [9:0] display_line;
  logic       composer_line_done;
  logic       sprites_enable;
  logic       render_done;
  logic       overrun_clr;
  logic       active_render_buffer;
  logic       render_start;
  logic [9:0] render_line;
  logic       render_abort;
  logic       composer_erase_start;
  logic [1:0] status;
  modport master (
    output line_start, display_line, composer_line_done, sprites_enable, render_done, overrun_clr,
    input  active_render_buffer, render_start, render_line, render_abort, composer_erase_start, status
  );
  modport slave (
    input  line_start, display_line, composer_line_done, sprites_enable, render_done, overrun_clr,
    output active_render_buffer, render_start, render_line, render_abort, composer_erase_start, status
  );
endinterface

// File: rtl/sprite_line_sequencer.sv
// sprite_line_sequencer: per-scanline buffer swap / erase / renderer launch controller
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of sprite_line_sequencer_if (timing, renderer and line-buffer signals)
module sprite_line_sequencer #(
  parameter int ERASE_CYCLES = 160,
  parameter int V_LINES      = 525
) (
  input logic clk,
  input logic rst_n,
  sprite_line_sequencer_if.slave bus
);
  localparam int CW = $clog2(ERASE_CYCLES + 1);
  logic [CW-1:0] r_erase_cnt;
  logic          r_swap_pending, r_render_busy, r_relaunch;
  logic          r_active, r_render_start, r_render_abort, r_erase_start;
  logic [9:0]    r_next_line, r_render_line;
  logic [1:0]    r_status;
  logic          w_erase_idle, w_erase_go, w_swap, w_busy, w_launch_now, w_relaunch;
  logic [9:0]    w_next_line, w_swap_line;
  logic [1:0]    w_status_set;
  always_comb begin
    w_erase_idle = r_erase_cnt == '0;
    w_erase_go   = bus.composer_line_done && w_erase_idle;
    // an erase starting this cycle blocks the swap so the renderer never gets a dirty buffer
    w_swap       = (bus.line_start || r_swap_pending) && w_erase_idle && !w_erase_go;
    w_next_line  = (bus.display_line == 10'(V_LINES - 1)) ? 10'd0 : bus.display_line + 10'd1;
    w_swap_line  = bus.line_start ? w_next_line : r_next_line;
    // a completion arriving with the swap counts as done, so no abort
    w_busy       = r_render_busy && !bus.render_done;
    w_launch_now = w_swap && bus.sprites_enable && !w_busy;
    w_relaunch   = w_swap && bus.sprites_enable && w_busy;
    w_status_set = {bus.line_start && r_swap_pending, w_relaunch};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_erase_cnt    <= '0;
      r_swap_pending <= 1'b0;
      r_render_busy  <= 1'b0;
      r_relaunch     <= 1'b0;
      r_active       <= 1'b0;
      r_render_start <= 1'b0;
      r_render_abort <= 1'b0;
      r_erase_start  <= 1'b0;
      r_next_line    <= '0;
      r_render_line  <= '0;
      r_status       <= '0;
    end else begin
      r_erase_start  <= w_erase_go;
      r_erase_cnt    <= w_erase_go ? CW'(ERASE_CYCLES) : r_erase_cnt - CW'(!w_erase_idle);
      r_next_line    <= bus.line_start ? w_next_line : r_next_line;
      r_swap_pending <= (r_swap_pending || bus.line_start) && !w_swap;
      r_active       <= r_active ^ w_swap;
      r_render_line  <= w_swap ? w_swap_line : r_render_line;
      r_render_abort <= w_relaunch;
      r_relaunch     <= w_relaunch;
      r_render_start <= w_launch_now || r_relaunch;
      // a swap always retires the previous line, whether it finished, was aborted or is suppressed
      r_render_busy  <= w_launch_now || r_relaunch || (w_busy && !w_swap);
      r_status       <= (bus.overrun_clr ? 2'b00 : r_status) | w_status_set;
    end
  end
  assign bus.active_render_buffer = r_active;
  assign bus.render_start         = r_render_start;
  assign bus.render_line          = r_render_line;
  assign bus.render_abort         = r_render_abort;
  assign bus.composer_erase_start = r_erase_start;
  assign bus.status               = r_status;
endmodule

// File: tb/tb_sprite_line_sequencer.sv
// tb_sprite_line_sequencer: directed stimulus with an event scoreboard for sprite_line_sequencer
module tb_sprite_line_sequencer;
  typedef struct {
    int         cyc;
    logic       er, st, ab, act;
    logic [9:0] line;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];
  ev_t  e;
  logic prev_act = 1'b0;
  sprite_line_sequencer_if bus();
  sprite_line_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_ev(input int c, input logic er, st, ab, act, input logic [9:0] ln);
    q.push_back('{c, er, st, ab, act, ln});
  endtask
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at cyc %0d", name, got, exp, cyc);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_active"}, int'(bus.active_render_buffer), 0);
    chk({tag, "_start"},  int'(bus.render_start), 0);
    chk({tag, "_abort"},  int'(bus.render_abort), 0);
    chk({tag, "_erase"},  int'(bus.composer_erase_start), 0);
    chk({tag, "_line"},   int'(bus.render_line), 0);
    chk({tag, "_status"}, int'(bus.status), 0);
  endtask
  // any pulse or buffer toggle is an event that must match the head of the queue
  always @(negedge clk) begin
    if (!rst_n) prev_act = 1'b0;
    else if (bus.composer_erase_start || bus.render_start || bus.render_abort ||
             bus.active_render_buffer != prev_act) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d er/st/ab/act=%b%b%b%b line=%0d",
                 cyc, bus.composer_erase_start, bus.render_start, bus.render_abort,
                 bus.active_render_buffer, bus.render_line);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.er !== bus.composer_erase_start || e.st !== bus.render_start ||
            e.ab !== bus.render_abort || e.act !== bus.active_render_buffer || e.line !== bus.render_line) begin
          errors++;
          $display("FAIL event got cyc=%0d er/st/ab/act=%b%b%b%b line=%0d exp cyc=%0d er/st/ab/act=%b%b%b%b line=%0d",
                   cyc, bus.composer_erase_start, bus.render_start, bus.render_abort,
                   bus.active_render_buffer, bus.render_line, e.cyc, e.er, e.st, e.ab, e.act, e.line);
        end
      end
      prev_act = bus.active_render_buffer;
    end
  end
  initial begin
    int t;
    logic       ea;
    logic [9:0] el;
    rst_n = 1'b1;
    bus.line_start = 1'b0;
    bus.display_line = '0;
    bus.composer_line_done = 1'b0;
    bus.sprites_enable = 1'b1;
    bus.render_done = 1'b0;
    bus.overrun_clr = 1'b0;
    #1 rst_n = 1'b0;
    step(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(2);
    // immediate swap with idle erase
    t = cyc;
    bus.line_start = 1'b1; bus.display_line = 10'd10;
    expect_ev(t + 1, 0, 1, 0, 1, 10'd11);
    step(1); bus.line_start = 1'b0;
    step(3); bus.render_done = 1'b1;
    step(1); bus.render_done = 1'b0;
    step(3);
    // swap deferred behind an erase
    t = cyc;
    bus.composer_line_done = 1'b1;
    expect_ev(t + 1, 1, 0, 0, 1, 10'd11);
    expect_ev(t + 162, 0, 1, 0, 0, 10'd101);
    step(1); bus.composer_line_done = 1'b0;
    step(49); bus.line_start = 1'b1; bus.display_line = 10'd100;
    step(1); bus.line_start = 1'b0;
    step(120);
    // renderer still busy: abort then relaunch
    t = cyc;
    bus.line_start = 1'b1; bus.display_line = 10'd200;
    expect_ev(t + 1, 0, 0, 1, 1, 10'd201);
    expect_ev(t + 2, 0, 1, 0, 1, 10'd201);
    step(1); bus.line_start = 1'b0;
    step(3);
    chk("overrun_set", int'(bus.status), 1);
    bus.overrun_clr = 1'b1;
    step(1); bus.overrun_clr = 1'b0;
    chk("overrun_clr", int'(bus.status), 0);
    step(2);
    // wrap at last line, completion coincident with swap
    t = cyc;
    bus.line_start = 1'b1; bus.display_line = 10'd524; bus.render_done = 1'b1;
    expect_ev(t + 1, 0, 1, 0, 0, 10'd0);
    step(1); bus.line_start = 1'b0; bus.render_done = 1'b0;
    step(2);
    chk("done_with_swap_status", int'(bus.status), 0);
    // overrun set in the same cycle as clear wins
    t = cyc;
    bus.line_start = 1'b1; bus.display_line = 10'd5; bus.overrun_clr = 1'b1;
    expect_ev(t + 1, 0, 0, 1, 1, 10'd6);
    expect_ev(t + 2, 0, 1, 0, 1, 10'd6);
    step(1); bus.line_start = 1'b0; bus.overrun_clr = 1'b0;
    chk("set_wins_over_clr", int'(bus.status), 1);
    step(2); bus.overrun_clr = 1'b1;
    step(1); bus.overrun_clr = 1'b0; bus.render_done = 1'b1;
    step(1); bus.render_done = 1'b0;
    chk("clr_again", int'(bus.status), 0);
    step(2);
    // two line starts during one erase: one swap from the second, dropped flag
    t = cyc;
    bus.composer_line_done = 1'b1;
    expect_ev(t + 1, 1, 0, 0, 1, 10'd6);
    expect_ev(t + 162, 0, 1, 0, 0, 10'd302);
    step(1); bus.composer_line_done = 1'b0;
    step(9); bus.line_start = 1'b1; bus.display_line = 10'd300;
    step(1); bus.line_start = 1'b0;
    step(9); bus.line_start = 1'b1; bus.display_line = 10'd301;
    step(1); bus.line_start = 1'b0;
    chk("swap_dropped", int'(bus.status), 2);
    step(149);
    bus.overrun_clr = 1'b1;
    step(1); bus.overrun_clr = 1'b0;
    chk("dropped_clr", int'(bus.status), 0);
    // sprites disabled, simultaneous line start and line done on each line
    bus.sprites_enable = 1'b0;
    ea = 1'b0; el = 10'd302;
    for (int k = 0; k < 3; k++) begin
      t = cyc;
      bus.line_start = 1'b1; bus.composer_line_done = 1'b1; bus.display_line = 10'(400 + k);
      expect_ev(t + 1, 1, 0, 0, ea, el);
      ea = ~ea; el = 10'(401 + k);
      expect_ev(t + 162, 0, 0, 0, ea, el);
      step(1); bus.line_start = 1'b0; bus.composer_line_done = 1'b0;
      step(169);
    end
    chk("disabled_status", int'(bus.status), 0);
    // reset in the middle of an erase with a swap pending
    bus.sprites_enable = 1'b1;
    t = cyc;
    bus.composer_line_done = 1'b1;
    expect_ev(t + 1, 1, 0, 0, 1, 10'd403);
    step(1); bus.composer_line_done = 1'b0;
    step(19); bus.line_start = 1'b1; bus.display_line = 10'd450;
    step(1); bus.line_start = 1'b0;
    step(20);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    step(2);
    rst_n = 1'b1;
    step(300);
    chk("post_reset_line", int'(bus.render_line), 0);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_line_sequencer.md
Name: sprite_line_sequencer

Overview:
- Per-scanline controller for the double-buffered sprite line buffer.
- Decides when to swap the render/composer buffers (drives `active_render_buffer`) and when to erase the displayed buffer (pulses `composer_erase_start`).
- Launches the sprite renderer for the next line and tracks its completion.
- Flags renderer overruns and dropped swaps.
- Sits between video timing, the sprite renderer and the line buffer.

Parameters:
- ERASE_CYCLES, 160, cycles the line buffer needs to finish an erase after `composer_erase_start`.
- V_LINES, 525, total lines per frame; `render_line` wraps modulo this value.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- line_start  input  1  one-cycle pulse at the start of each display line.
- display_line  input  10  line number being displayed, valid when `line_start`=1.
- composer_line_done  input  1  one-cycle pulse when the composer has finished reading the current line.
- sprites_enable  input  1  level; 0 suppresses renderer launches.
- render_done  input  1  one-cycle pulse from the renderer when its line is finished.
- overrun_clr  input  1  one-cycle pulse; clears both sticky flags.
- active_render_buffer  output  1  buffer-select to the line buffer.
- render_start  output  1  one-cycle pulse that launches the renderer.
- render_line  output  10  line the renderer must build; held stable between launches.
- render_abort  output  1  one-cycle pulse telling the renderer to stop its current line.
- composer_erase_start  output  1  one-cycle pulse to the line buffer erase logic.
- status  output  2  bit0 = render overrun (sticky); bit1 = swap dropped (sticky).

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - Every output 0, including `active_render_buffer`, `render_line` and `status`.
  - Internal state cleared: `erase_cnt`=0, `swap_pending`=0, `render_busy`=0.
  - Reset mid-line abandons any erase or render in progress; no pulses are issued after release until new events arrive.
- All outputs are registered.
- Erase:
  - `composer_line_done` seen with `erase_cnt`==0: `composer_erase_start`=1 in the next cycle, and `erase_cnt` loads ERASE_CYCLES in that same cycle.
  - `erase_cnt` then decrements by 1 per cycle to 0.
  - `composer_line_done` seen while `erase_cnt`!=0 is ignored.
- Swap request:
  - `line_start` at cycle T latches `display_line` into `next_line` = (`display_line`+1) mod V_LINES. At `display_line`=V_LINES-1 this gives 0.
  - Swap is permitted only when `erase_cnt`==0 and no erase start is issuing in the same cycle.
  - If not permitted, set `swap_pending`.
  - If `line_start` arrives while `swap_pending`=1: set `status[1]`, overwrite `next_line`, keep a single pending swap.
- Swap execution (cycle S, which is T+1, or the cycle after `erase_cnt` reaches 0 when pending):
  - Toggle `active_render_buffer`; `render_line` <= `next_line`; clear `swap_pending`.
  - If `render_busy`=1 at S: `render_abort`=1 at S, `status[0]` set, `render_busy` cleared.
  - Launch `render_start` at S+1 in that case, otherwise at S.
  - `render_start` is issued only if `sprites_enable`=1 at S. When issued, `render_busy` is set.
- Renderer completion:
  - `render_done` clears `render_busy`.
  - `render_done` while not busy is ignored.
  - `render_done` in the same cycle as swap execution counts as done: no abort and no overrun.
- Simultaneous `line_start` and `composer_line_done` with `erase_cnt`==0:
  - The erase is issued first.
  - The swap goes pending and executes the cycle after `erase_cnt` returns to 0.
  - This guarantees the buffer handed to the renderer is clean.
- `active_render_buffer` never toggles while `erase_cnt`!=0.
- `overrun_clr` clears `status` next cycle. A set event in the same cycle wins.
- `sprites_enable`=0: swaps and erases continue unchanged; no `render_start` or `render_abort` is issued.

Test Plan:
- Reset, then `line_start` with `display_line`=10 and an idle erase → `active_render_buffer`=1 at T+1, `render_start` 1 cycle at T+1, `render_line`=11.
- `composer_line_done`, then `line_start` 50 cycles later → erase start pulses once; swap deferred to exactly 161 cycles after the erase pulse; `render_line` correct; no toggle during the erase.
- `line_start` with `render_done` never returned → `render_abort` at S, `render_start` at S+1, `status`=2'b01; `overrun_clr` → `status`=0.
- `display_line`=524 → `render_line`=0; `render_done` coincident with the swap → no abort, `status[0]`=0.
- Two `line_start` pulses during one erase → `status[1]`=1, exactly one swap, `render_line` taken from the second pulse.
- `sprites_enable`=0 over 3 lines → three toggles and erases, zero `render_start`; assert `rst_n` mid-erase → all outputs 0 immediately and no erase pulse after release.
